// File: rtl/bus_arbiter.sv
// Bus phase generator and CPU/video arbiter: derives phi0, DRAM strobes and latch
// enables from a free-running tick counter, and runs the BA/AEC stall sequence for video DMA.
module bus_arbiter #(
  parameter int PHASE_TICKS  = 4,
  parameter int STALL_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  output logic phi0,
  output logic _aec,
  output logic ba,
  output logic _ras,
  output logic _cas,
  output logic cpu_en,
  output logic vic_en,
  output logic cycle_start
);

  localparam int TICKS = 2 * PHASE_TICKS;
  localparam int TW    = $clog2(TICKS);
  localparam logic [TW-1:0] LAST_TICK   = TW'(TICKS - 1);
  localparam logic [TW-1:0] PHASE_START = TW'(PHASE_TICKS);
  localparam logic [TW-1:0] PHASE_LAST  = TW'(PHASE_TICKS - 1);
  localparam logic [2:0]    STALL_MAX   = 3'(STALL_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEAL = 2'd2
  } state_e;

  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    count_q, count_d;
  logic          req_q, req_d;
  state_e        state_q, state_d;

  logic phi0_q, phi0_d;
  logic aec_q, aec_d;
  logic ba_q, ba_d;
  logic ras_q, ras_d;
  logic cas_q, cas_d;
  logic cpuEn_q, cpuEn_d;
  logic vicEn_q, vicEn_d;
  logic cycleStart_q, cycleStart_d;

  logic          inPhi2;
  logic [TW-1:0] phaseTick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q       <= '0;
      count_q      <= '0;
      req_q        <= 1'b0;
      state_q      <= IDLE;
      phi0_q       <= 1'b0;
      aec_q        <= 1'b1;
      ba_q         <= 1'b1;
      ras_q        <= 1'b1;
      cas_q        <= 1'b1;
      cpuEn_q      <= 1'b0;
      vicEn_q      <= 1'b0;
      cycleStart_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      count_q      <= count_d;
      req_q        <= req_d;
      state_q      <= state_d;
      phi0_q       <= phi0_d;
      aec_q        <= aec_d;
      ba_q         <= ba_d;
      ras_q        <= ras_d;
      cas_q        <= cas_d;
      cpuEn_q      <= cpuEn_d;
      vicEn_q      <= vicEn_d;
      cycleStart_q <= cycleStart_d;
    end
  end

  // The edge leaving the last tick captures dma_req and moves the FSM together, so the
  // new owner state is already in force (and visible on ba) at tick 0 of the next cycle.
  always_comb begin
    tick_d  = (tick_q == LAST_TICK) ? '0 : tick_q + TW'(1);
    req_d   = req_q;
    state_d = state_q;
    count_d = count_q;
    if (tick_q == LAST_TICK) begin
      req_d = dma_req;
      case (state_q)
        IDLE: begin
          if (dma_req) begin
            state_d = WAIT;
            count_d = 3'd1;
          end
        end
        WAIT: begin
          if (!dma_req) begin
            state_d = IDLE;
            count_d = '0;
          end else if (count_q < STALL_MAX) begin
            count_d = count_q + 3'd1;
          end else begin
            state_d = STEAL;
          end
        end
        STEAL: begin
          if (!dma_req) begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the upcoming tick and state so the registers line up with tick_q.
  always_comb begin
    inPhi2       = (tick_d >= PHASE_START);
    phaseTick    = inPhi2 ? (tick_d - PHASE_START) : tick_d;
    phi0_d       = inPhi2;
    cycleStart_d = (tick_d == '0);
    ras_d        = (phaseTick == '0);
    cas_d        = (phaseTick < TW'(2));
    ba_d         = (state_d == IDLE);
    aec_d        = !inPhi2 || (state_d == STEAL);
    cpuEn_d      = (tick_d == LAST_TICK) && (state_d != STEAL);
    vicEn_d      = (tick_d == PHASE_LAST) || ((tick_d == LAST_TICK) && (state_d == STEAL));
  end

  assign phi0        = phi0_q;
  assign _aec        = aec_q;
  assign ba          = ba_q;
  assign _ras        = ras_q;
  assign _cas        = cas_q;
  assign cpu_en      = cpuEn_q;
  assign vic_en      = vicEn_q;
  assign cycle_start = cycleStart_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter at PHASE_TICKS=4, STALL_CYCLES=3: per-cycle vector table expanded
// into per-tick expectations on a scoreboard queue, plus a mid-STEAL async reset sequence.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dma_req = 1'b0;
  logic phi0, aec, ba, ras, cas, cpuEn, vicEn, cycleStart;

  bus_arbiter #(.PHASE_TICKS(4), .STALL_CYCLES(3)) dut (
    .clk(clk),
    .reset(reset),
    .dma_req(dma_req),
    .phi0(phi0),
    ._aec(aec),
    .ba(ba),
    ._ras(ras),
    ._cas(cas),
    .cpu_en(cpuEn),
    .vic_en(vicEn),
    .cycle_start(cycleStart)
  );

  always #5 clk = ~clk;

  // One row per bus cycle: req is the dma_req level captured for this cycle.
  typedef struct {
    logic  req;
    logic  ba;
    logic  steal;
    logic  glitch;
    string name;
  } vec_t;

  typedef struct {
    logic [7:0] outs;
    string      name;
    int         tick;
  } exp_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  // Bit k of each pattern is the level at tick k for P = 4.
  logic [7:0] phi0Pat = 8'b1111_0000;
  logic [7:0] rasPat  = 8'b0001_0001;
  logic [7:0] casPat  = 8'b0011_0011;
  logic [7:0] vicPat  = 8'b0000_1000;
  logic [7:0] resetVec = 8'b0_1_1_1_1_0_0_0;

  function automatic logic [7:0] expVec(int k, logic expBa, logic steal);
    logic p, a, r, c, ce, ve, cs;
    p  = phi0Pat[k];
    a  = !phi0Pat[k] || steal;
    r  = rasPat[k];
    c  = casPat[k];
    ce = (k == 7) && !steal;
    ve = vicPat[k] || ((k == 7) && steal);
    cs = (k == 0);
    return {p, a, expBa, r, c, ce, ve, cs};
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic [7:0] got;
    got = {phi0, aec, ba, ras, cas, cpuEn, vicEn, cycleStart};
    checks++;
    if (scoreboard.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard empty: got %b", got);
    end else begin
      e = scoreboard.pop_front();
      if (got !== e.outs) begin
        errors++;
        $display("[TB] FAIL %s tick %0d: got {phi0,aec,ba,ras,cas,cpu,vic,cs}=%b expected %b",
                 e.name, e.tick, got, e.outs);
      end
    end
  endtask

  task automatic applyStimulus(logic reqVal, int k, logic [7:0] outs, string name);
    exp_t e;
    dma_req = reqVal;
    e.outs = outs;
    e.name = name;
    e.tick = k;
    scoreboard.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runPartial(string name);
    for (int k = 1; k < 8; k++) applyStimulus(1'b0, k, expVec(k, 1'b1, 1'b0), name);
  endtask

  task automatic runCycle(vec_t v, int lastTick);
    logic r;
    for (int k = 0; k <= lastTick; k++) begin
      r = v.req;
      if (v.glitch) r = (k >= 2 && k <= 4);
      applyStimulus(r, k, expVec(k, v.ba, v.steal), v.name);
    end
  endtask

  task automatic checkReset(string name);
    exp_t e;
    e.outs = resetVec;
    e.name = name;
    e.tick = 0;
    scoreboard.push_back(e);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "freerun0"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "freerun1"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "hold_wait1"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "hold_wait2"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "hold_wait3"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, "hold_steal1"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, "hold_steal2"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "drop_idle"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "idle"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "short_wait1"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "short_wait2"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "short_release"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, "glitch"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "after_glitch"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "pre_reset_wait1"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "pre_reset_wait2"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "pre_reset_wait3"});

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset_state");
    reset = 1'b0;
    runPartial("first_partial");

    foreach (vecs[i]) runCycle(vecs[i], 7);

    // Enter STEAL, then hit reset asynchronously while tick 5 is showing.
    runCycle('{1'b1, 1'b0, 1'b1, 1'b0, "steal_before_reset"}, 5);
    #1 reset = 1'b1;
    #1 checkReset("async_reset_mid_steal");
    @(posedge clk);
    @(negedge clk);
    checkReset("reset_held");
    reset = 1'b0;
    runPartial("post_reset_partial");
    runCycle('{1'b1, 1'b0, 1'b0, 1'b0, "rereq_wait1"}, 7);
    runCycle('{1'b1, 1'b0, 1'b0, 1'b0, "rereq_wait2"}, 7);
    runCycle('{1'b1, 1'b0, 1'b0, 1'b0, "rereq_wait3"}, 7);
    runCycle('{1'b1, 1'b0, 1'b1, 1'b0, "rereq_steal"}, 7);
    runCycle('{1'b0, 1'b1, 1'b0, 1'b0, "rereq_drop"}, 7);

    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard leftover: got %0d entries expected 0", scoreboard.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Generates the system bus phase timing and shares the single memory bus between the CPU and the video chip.
- Drives the `_aec`, `ba` and `_cas` inputs consumed by the address-decode PLA, plus RAM strobes and per-requester data-latch enables.
- Handles the CPU-stall sequence for video DMA (badlines/sprites): BA goes low three bus cycles before the video chip takes the CPU half-cycle.
- Sits between the clock source and the PLA, CPU RDY/AEC and the video-chip fetch logic.

Parameters:
- PHASE_TICKS, 4, clk ticks per half bus cycle (phi1 or phi2). Legal range 3..16; a bus cycle is 2*PHASE_TICKS ticks.
- STALL_CYCLES, 3, number of bus cycles BA is low before the CPU half-cycle is stolen. Legal range 1..7.

Ports:
- clk  input  1  master clock
- reset  input  1  asynchronous, active-high reset
- dma_req  input  1  video chip requests the phi2 half-cycles (level, held while DMA is needed)
- phi0  output  1  bus phase: 0 = phi1 (video half), 1 = phi2 (CPU half)
- _aec  output  1  1 = video chip owns address bus, 0 = CPU owns it; feeds PLA `_AEC` and CPU AEC
- ba  output  1  bus available; 0 = DMA pending or active; feeds PLA `BA` and CPU RDY
- _ras  output  1  DRAM row strobe, active low
- _cas  output  1  DRAM column strobe, active low; feeds PLA `_CAS`
- cpu_en  output  1  one-tick pulse: CPU data may be latched or committed this tick
- vic_en  output  1  one-tick pulse: video chip data latch
- cycle_start  output  1  one-tick pulse at tick 0 of every bus cycle

Behaviour:
- Tick counter `t`, width to hold 0..2*PHASE_TICKS-1.
  - Increments every clk and wraps to 0 after 2*PHASE_TICKS-1.
  - Runs freely; no other input affects it.
- Phase and strobes:
  - phi0 = 0 for t in 0..P-1 and 1 for t in P..2P-1, where P = PHASE_TICKS.
  - cycle_start = 1 when t == 0.
  - _ras = 0 for t in 1..P-1 and P+1..2P-1; 1 at t == 0 and t == P.
  - _cas = 0 for t in 2..P-1 and P+2..2P-1; otherwise 1.
  - Strobes run every half-cycle regardless of owner; the PLA gates them.
- All outputs are registered. The values above are the registered output at each t; there is no combinational path from any input to any output.
- dma_req is sampled into `req_q` only at t == 2P-1. That sample governs the next bus cycle.
- FSM, transitions only at t == 0 using req_q:
  - IDLE: ba = 1. If req_q → WAIT with stall count = 1; else stay IDLE.
  - WAIT: ba = 0 and the CPU still owns phi2.
    - If !req_q → IDLE.
    - Else if count < STALL_CYCLES → count+1.
    - Else (count == STALL_CYCLES) → STEAL.
  - STEAL: ba = 0 and the video chip owns phi2. If !req_q → IDLE; else stay STEAL.
  - The effect is STALL_CYCLES full WAIT cycles before the first stolen cycle.
- `_aec`:
  - 1 for t in 0..P-1 (every phi1).
  - For t in P..2P-1: 1 if state == STEAL, else 0.
- `cpu_en`: pulse at t == 2P-1 when the state in force for the cycle is not STEAL.
- `vic_en`: pulse at t == P-1 every cycle, and additionally at t == 2P-1 when the state is STEAL.
- `ba` and state change only at cycle boundaries; no mid-cycle glitches.
- A dma_req pulse that is not high at t == 2P-1 is ignored.
- Reset, asynchronous and effective immediately, including mid-STEAL:
  - Counters and state: t = 0, state = IDLE, count = 0, req_q = 0.
  - Outputs: phi0 = 0, _aec = 1, ba = 1, _ras = 1, _cas = 1, cpu_en = 0, vic_en = 0, cycle_start = 0.
  - On release, the first clk edge yields t = 1; the first cycle_start appears after a full wrap.

Test Plan:
- Free-run after reset, P = 4:
  - phi0 period is 8 clk, high 4 clk.
  - _ras low 3 clk and _cas low 2 clk in each half.
  - cycle_start, cpu_en and vic_en each pulse once per 8 clk.
  - _aec = 1 only while phi0 = 0.
- dma_req held high from cycle N onward:
  - ba = 0 from tick 0 of N+1.
  - cpu_en pulses in N+1, N+2, N+3.
  - From N+4, _aec = 1 for all 8 ticks, there is no cpu_en, and vic_en pulses twice per cycle.
- dma_req dropped while in STEAL:
  - The next cycle has ba = 1.
  - _aec = 0 during that cycle's phi2.
  - cpu_en resumes in that same cycle.
- dma_req high for only 2 sampled cycles:
  - ba is low for exactly 2 cycles.
  - _aec never goes high during phi2.
  - cpu_en is never missed.
- dma_req pulses high for 3 clk between samples → no effect on ba, _aec or cpu_en.
- Reset asserted at t = 5 during STEAL:
  - All outputs take reset values the same cycle, without waiting for clk.
  - After release, an immediate re-request still needs 3 WAIT cycles before the steal.
